// File: rtl/fetch_unit.sv
// fetch_unit: fetches instruction words over a req/ack handshake while the control unit is in FETCH
module fetch_unit #(
   parameter int         ADDR_W   = 8,
   parameter int         INSTR_W  = 16,
   parameter logic [3:0] ST_FETCH = 4'd1,
   parameter logic [3:0] OP_NOP   = 4'd0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [3:0]         uc_state,
   input  logic               pc_load,
   input  logic [ADDR_W-1:0]  pc_load_val,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [3:0]         instruction,
   output logic [3:0]         rd,
   output logic [3:0]         ra,
   output logic [3:0]         rb,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] pc_n, addr_n;
   logic [INSTR_W-1:0] ir, ir_n;
   logic req_n, valid_n, discard, discard_n, armed, armed_n, fetch;
   assign fetch = uc_state == ST_FETCH;
   assign instruction = instr_valid ? ir[INSTR_W-1 -: 4] : OP_NOP;
   assign rd = ir[11:8];
   assign ra = ir[7:4];
   assign rb = ir[3:0];
   // state register; reset drops the request at once so a late ack finds the unit idle
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         pc          <= '0;
         ir          <= '0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         instr_valid <= 1'b0;
         discard     <= 1'b0;
         armed       <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         ir          <= ir_n;
         mem_req     <= req_n;
         mem_addr    <= addr_n;
         instr_valid <= valid_n;
         discard     <= discard_n;
         armed       <= armed_n;
      end
   // next state; armed means the control unit has seen this word in FETCH, so leaving FETCH consumes it
   always_comb begin
      state_n   = state;
      pc_n      = pc_load ? pc_load_val : pc;
      ir_n      = ir;
      req_n     = mem_req;
      addr_n    = mem_addr;
      valid_n   = instr_valid;
      discard_n = discard;
      armed_n   = armed;
      case (state)
         IDLE: if (fetch) begin
            req_n   = 1'b1;
            addr_n  = pc;
            state_n = REQ;
         end
         REQ: if (mem_ack) begin
            if (pc_load) begin
               addr_n    = pc_load_val;
               discard_n = 1'b0;
            end else if (discard) begin
               addr_n    = pc;
               discard_n = 1'b0;
            end else begin
               ir_n    = mem_rdata;
               pc_n    = pc + 1'b1;
               valid_n = 1'b1;
               req_n   = 1'b0;
               armed_n = fetch;
               state_n = HOLD;
            end
         end else if (pc_load) discard_n = 1'b1;
         HOLD: if (pc_load || ir[INSTR_W-1 -: 4] == OP_NOP || (armed && !fetch)) begin
            valid_n = 1'b0;
            state_n = IDLE;
         end else armed_n = armed | fetch;
         default: state_n = IDLE;
      endcase
   end
endmodule
